gf180mcu_fd_sc_mcu9t5v0__oai21_pipe: RTL
========================================

GF180MCU_FD_SC_MCU9T5V0__OAI21_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__oai21_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RN.
REQ-002 Parameter WIDTH, default 8: bit width of every data lane; legal range 1..64.
REQ-003 Parameter STAGES, default 2: number of pipeline register stages; legal range 1..4.
REQ-004 Illegal parameter values SHALL cause an elaboration-time error.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RN  input  1  asynchronous active-low reset.
REQ-007 IN_VALID  input  1  input transaction present.
REQ-008 IN_READY  output  1  block accepts the input transaction this cycle.
REQ-009 A1  input  WIDTH  first OR/AND operand vector.
REQ-010 A2  input  WIDTH  second OR/AND operand vector.
REQ-011 B  input  WIDTH  third operand vector.
REQ-012 MODE  input  1  operation select: 0 = OAI21, 1 = AOI21; captured with the transaction.
REQ-013 OUT_VALID  output  1  ZN holds a valid result.
REQ-014 OUT_READY  input  1  consumer accepts the result.
REQ-015 ZN  output  WIDTH  result vector.
REQ-016 OCC  output  clog2(STAGES+1)  number of occupied stages.
REQ-017 When USE_POWER_PINS is defined, the block SHALL add inout VDD and VSS ports with no functional effect.

Function
REQ-018 When MODE=0, the result SHALL be computed bitwise as ZN[i] = ~((A1[i] | A2[i]) & B[i]).
REQ-019 When MODE=1, the result SHALL be computed bitwise as ZN[i] = ~((A1[i] & A2[i]) | B[i]).
REQ-020 The result SHALL be computed from the inputs at the moment of acceptance and then carried unchanged through the pipeline.
REQ-021 A transfer SHALL occur on a rising CLK edge when IN_VALID=1 and IN_READY=1 (input side), or when OUT_VALID=1 and OUT_READY=1 (output side).
REQ-022 Each stage k SHALL hold a valid bit and a WIDTH-bit data register.
REQ-023 Stage k SHALL load from stage k-1, or from the input when k=0, when stage k is empty or stage k+1 is advancing.
REQ-024 The last stage SHALL advance when OUT_READY=1.
REQ-025 Empty stages SHALL be filled (bubble collapse), so no bubble persists while downstream is stalled.
REQ-026 IN_READY SHALL equal (stage 0 empty) OR (stage 0 advancing); the combinational path from OUT_READY to IN_READY is permitted.
REQ-027 OUT_VALID SHALL be the last stage's valid bit, and ZN SHALL be the last stage's data register.
REQ-028 With no stalls, latency SHALL be exactly STAGES cycles from the input transfer edge to OUT_VALID=1, and throughput SHALL be one transaction per cycle.
REQ-029 While OUT_VALID=1 and OUT_READY=0, ZN and OUT_VALID SHALL remain stable.
REQ-030 When all STAGES stages are full and OUT_READY=0, IN_READY SHALL be 0 and OCC SHALL equal STAGES.
REQ-031 When full and OUT_READY=1, a simultaneous input and output transfer SHALL be accepted, and OCC SHALL be unchanged.
REQ-032 Transactions SHALL leave in acceptance order, with no loss or duplication.
REQ-033 OCC SHALL equal the count of set valid bits, incrementing on an input-only transfer and decrementing on an output-only transfer.
REQ-034 IN_VALID=0 cycles SHALL NOT alter the contents of occupied stages.
REQ-035 A1, A2, B and MODE SHALL be ignored when IN_READY=0 or IN_VALID=0.

Reset
REQ-036 While RN=0, all valid bits SHALL be 0, all data registers SHALL be 0, OUT_VALID SHALL be 0, ZN SHALL be all zeros, and OCC SHALL be 0, independent of CLK.
REQ-037 Assertion of RN mid-operation SHALL discard all in-flight transactions immediately.
REQ-038 IN_READY SHALL be 1 during and after reset.
REQ-039 Deassertion of RN SHALL be synchronised by the integrator, and the first transfer SHALL be allowed on the first CLK edge after release.

Verification (WIDTH=4, STAGES=2)
REQ-040 The bench SHALL cover: OAI21 with A1=0011, A2=0101, B=1111, MODE=0, OUT_READY=1 -> ZN=1000 with OUT_VALID=1 exactly 2 cycles after the transfer.
REQ-041 The bench SHALL cover: AOI21 with A1=0011, A2=0101, B=0110, MODE=1 -> ZN=1000; the same operands with MODE=0 -> ZN=1001.
REQ-042 The bench SHALL cover: back-to-back transfers T1=(0011,0101,1111,0) then T2=(0011,0101,0110,0) -> ZN=1000 then 1001 on consecutive cycles, OCC=2 at steady state.
REQ-043 The bench SHALL cover backpressure: OUT_READY=0 while 3 transfers are offered -> 2 accepted, IN_READY=0, OCC=2, ZN held at the first result; OUT_READY=1 -> results drain in order, and the third transfer is accepted in the same cycle as the first drain.
REQ-044 The bench SHALL cover full-plus-simultaneous transfer: pipeline full, OUT_READY=1, IN_VALID=1 -> one output and one input transfer per cycle, OCC stays 2.
REQ-045 The bench SHALL cover reset mid-flight: RN=0 with OCC=2 -> OUT_VALID=0, ZN=0000, and OCC=0 asynchronously; after release, a new transfer appears 2 cycles later with no remnant of earlier data.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai21_pipe.sv
// Elastic OAI21/AOI21 pipeline: result computed at acceptance, then carried
// through STAGES valid/data registers with bubble collapse and backpressure.

module gf180mcu_fd_sc_mcu9t5v0__oai21_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    // Data only captured with a valid token, so empty stages keep quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld <= vld_in;
            if (vld_in) data <= data_in;
        end
    end

endmodule

module gf180mcu_fd_sc_mcu9t5v0__oai21_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
`ifdef USE_POWER_PINS
    inout  wire                         VDD,
    inout  wire                         VSS,
`endif
    input  logic                        CLK,
    input  logic                        RN,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [WIDTH-1:0]            A1,
    input  logic [WIDTH-1:0]            A2,
    input  logic [WIDTH-1:0]            B,
    input  logic                        MODE,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [WIDTH-1:0]            ZN,
    output logic [$clog2(STAGES+1)-1:0] OCC
);

    localparam int OCC_W = $clog2(STAGES + 1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("STAGES must be in 1..4");
    end

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            move;
    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [WIDTH-1:0]             result;
    logic                         in_fire;
    logic                         out_fire;

    assign result = MODE ? ~((A1 & A2) | B) : ~((A1 | A2) & B);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_vld;
        logic [WIDTH-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_vld  = IN_VALID;
            assign src_data = result;
        end else begin : g_body
            assign src_vld  = vld[k-1];
            assign src_data = data[k-1];
        end

        // Stage k can take new contents unless it and every stage below it
        // are full while the consumer stalls.
        assign move[k] = OUT_READY | ~(&vld[STAGES-1:k]);

        gf180mcu_fd_sc_mcu9t5v0__oai21_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (CLK),
            .rst_n   (RN),
            .load    (move[k]),
            .vld_in  (src_vld),
            .data_in (src_data),
            .vld     (vld[k]),
            .data    (data[k])
        );
    end

    assign IN_READY  = move[0];
    assign OUT_VALID = vld[STAGES-1];
    assign ZN        = data[STAGES-1];
    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            OCC <= '0;
        end else if (in_fire && !out_fire) begin
            OCC <= OCC + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            OCC <= OCC - OCC_W'(1);
        end
    end

endmodule
